// File: rtl/fetch_pkg.sv
// Shared types for the fetch front end: FSM states, fetch-queue entry layout, PC adder.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
package fetch_pkg;

    localparam int unsigned ENTRY_W       = 160;
    localparam logic [31:0] HALT_INST_DEF = 32'h0000_0073;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2,
        ST_FAULT = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic [63:0] pc4;
    } fq_entry_t;

    // Shared sequential-PC adder; wraps modulo 2^64.
    function automatic logic [63:0] pc_add4(input logic [63:0] pc);
        return pc + 64'd4;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Generic synchronous FIFO with flush; head is read combinationally from storage.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: a push while full is accepted only together with a pop; flush wins over both.
module fetch_queue #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 160
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign rdata   = mem[rd_ptr];
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked entirely by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch control: owns the PC, drives imem, handles redirect/halt/fault, queues fetched words.
// Latency: one cycle from fetch to dec_valid; one instruction per cycle with dec_ready held.
// Backpressure: fetch stalls while the queue is full and decode is not taking the head.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter logic [63:0] IMEM_BYTES = 64'd64,
    parameter logic [31:0] HALT_INST  = HALT_INST_DEF,
    parameter int unsigned FQ_DEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_inst,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_target,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [63:0] dec_pc,
    output logic [31:0] dec_inst,
    output logic [63:0] dec_pc4,
    output logic        halted,
    output logic        fault
);

    localparam int unsigned CW = $clog2(FQ_DEPTH) + 1;

    fetch_state_t       state;
    logic [63:0]        pc;
    logic [63:0]        pc4;
    logic               redirect_take;
    logic               pop;
    logic               space;
    logic               bad_pc;
    logic               fetch_en;
    logic               push;
    logic               q_full;
    logic               q_empty;
    logic [CW-1:0]      q_count;
    logic [ENTRY_W-1:0] q_rdata;
    fq_entry_t          wr_entry;
    fq_entry_t          head;

    assign pc4           = pc_add4(pc);
    assign imem_addr     = pc;
    assign redirect_take = redirect_valid && (state != ST_BOOT);
    assign pop           = dec_valid && dec_ready;
    assign space         = (q_count < CW'(FQ_DEPTH)) || (q_full && pop);
    assign bad_pc        = (pc >= IMEM_BYTES) || (pc[1:0] != 2'b00);
    assign fetch_en      = (state == ST_RUN) && !redirect_take && space;
    assign push          = fetch_en && !bad_pc;

    assign wr_entry = '{pc: pc, inst: imem_inst, pc4: pc4};
    assign head     = fq_entry_t'(q_rdata);

    fetch_queue #(
        .DEPTH (FQ_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_take),
        .push  (push),
        .pop   (pop),
        .wdata (wr_entry),
        .rdata (q_rdata),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    // Outputs read as zero when the queue is empty so decode never sees stale storage.
    assign dec_valid = !q_empty;
    assign dec_pc    = q_empty ? 64'h0 : head.pc;
    assign dec_inst  = q_empty ? 32'h0 : head.inst;
    assign dec_pc4   = q_empty ? 64'h0 : head.pc4;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_BOOT;
            pc     <= RESET_PC;
            halted <= 1'b0;
            fault  <= 1'b0;
        end else if (redirect_take) begin
            // Fault stays sticky; a bad target is caught by the next fetch check.
            state  <= ST_RUN;
            pc     <= redirect_target;
            halted <= 1'b0;
        end else begin
            case (state)
                ST_BOOT: state <= ST_RUN;
                ST_RUN: begin
                    if (fetch_en) begin
                        if (bad_pc) begin
                            fault <= 1'b1;
                            state <= ST_FAULT;
                        end else begin
                            pc <= pc4;
                            if (imem_inst == HALT_INST) begin
                                state  <= ST_HALT;
                                halted <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= state;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: stimulus queues expected decode entries,
// an independent monitor pops and compares whenever decode accepts an entry.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] imem_addr;
    logic [31:0] imem_inst;
    logic        redirect_valid;
    logic [63:0] redirect_target;
    logic        dec_valid;
    logic        dec_ready;
    logic [63:0] dec_pc;
    logic [31:0] dec_inst;
    logic [63:0] dec_pc4;
    logic        halted;
    logic        fault;
    logic [63:0] halt_at;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return {8'hA5, a[23:0]};
    endfunction

    assign imem_inst = (imem_addr == halt_at) ? 32'h0000_0073 : mem_word(imem_addr);

    fetch_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .imem_addr       (imem_addr),
        .imem_inst       (imem_inst),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .dec_valid       (dec_valid),
        .dec_ready       (dec_ready),
        .dec_pc          (dec_pc),
        .dec_inst        (dec_inst),
        .dec_pc4         (dec_pc4),
        .halted          (halted),
        .fault           (fault)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic expect_pc(input logic [63:0] pc, input logic is_halt);
        exp_t e;
        e.pc   = pc;
        e.inst = is_halt ? 32'h0000_0073 : mem_word(pc);
        exp_q.push_back(e);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted head must match the next queued expectation.
    always @(negedge clk) begin
        if (!rst && dec_valid && dec_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_entry: got pc %h, expected no entry", dec_pc);
            end else begin
                mon_e = exp_q.pop_front();
                check("dec_pc", dec_pc, mon_e.pc);
                check("dec_inst", 64'(dec_inst), 64'(mon_e.inst));
                check("dec_pc4", dec_pc4, mon_e.pc + 64'd4);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int k;
        rst             = 1'b1;
        dec_ready       = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = 64'h0;
        halt_at         = '1;
        repeat (3) tick;

        check("rst_dec_valid", 64'(dec_valid), 64'd0);
        check("rst_imem_addr", imem_addr, 64'h0);
        check("rst_halted", 64'(halted), 64'd0);
        check("rst_fault", 64'(fault), 64'd0);
        check("rst_dec_pc", dec_pc, 64'h0);
        check("rst_dec_inst", 64'(dec_inst), 64'd0);
        check("rst_dec_pc4", dec_pc4, 64'h0);

        // Streaming from reset: 0,4,8,C accepted before decode stalls.
        for (int i = 0; i < 4; i++) expect_pc(64'(i * 4), 1'b0);
        rst = 1'b0;
        tick;
        check("boot_no_valid", 64'(dec_valid), 64'd0);
        tick;
        check("first_valid", 64'(dec_valid), 64'd1);
        check("first_pc", dec_pc, 64'h0);
        repeat (4) tick;
        dec_ready = 1'b0;

        // Stall: queue fills with 0x10,0x14, pc parks at 0x18.
        for (int i = 0; i < 5; i++) begin
            tick;
            check("stall_head_stable", dec_pc, 64'h10);
        end
        check("stall_pc", imem_addr, 64'h18);
        check("phase1_drained", 64'(exp_q.size()), 64'd0);

        // Redirect to 0x0C flushes 0x10/0x14; then run into the halt word at 0x1C.
        halt_at = 64'h1C;
        expect_pc(64'h0C, 1'b0);
        expect_pc(64'h10, 1'b0);
        expect_pc(64'h14, 1'b0);
        expect_pc(64'h18, 1'b0);
        expect_pc(64'h1C, 1'b1);
        redirect_valid  = 1'b1;
        redirect_target = 64'h0C;
        tick;
        redirect_valid = 1'b0;
        check("redir_flush", 64'(dec_valid), 64'd0);
        check("redir_pc", imem_addr, 64'h0C);
        tick;
        check("redir_first_valid", 64'(dec_valid), 64'd1);
        check("redir_first_pc", dec_pc, 64'h0C);
        dec_ready = 1'b1;

        k = 0;
        while (!halted && k < 50) begin
            tick;
            k++;
        end
        check("halt_seen", 64'(halted), 64'd1);
        check("halt_pc", imem_addr, 64'h20);
        repeat (6) tick;
        check("halt_frozen", imem_addr, 64'h20);
        check("halt_drained_valid", 64'(dec_valid), 64'd0);
        check("halt_drained_q", 64'(exp_q.size()), 64'd0);

        // Redirect to 0 clears halt; sequential fetch walks 0..0x3C then faults at 0x40.
        halt_at = '1;
        for (int i = 0; i < 16; i++) expect_pc(64'(i * 4), 1'b0);
        redirect_valid  = 1'b1;
        redirect_target = 64'h0;
        tick;
        redirect_valid = 1'b0;
        check("redir_clears_halt", 64'(halted), 64'd0);
        check("redir_resume_pc", imem_addr, 64'h0);

        k = 0;
        while (!fault && k < 100) begin
            tick;
            k++;
        end
        check("range_fault", 64'(fault), 64'd1);
        repeat (4) tick;
        check("fault_drained_valid", 64'(dec_valid), 64'd0);
        check("fault_pc", imem_addr, 64'h40);
        check("fault_drained_q", 64'(exp_q.size()), 64'd0);

        // Redirect out of FAULT: fetch resumes, fault stays sticky; let the queue fill.
        dec_ready       = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 64'h0;
        tick;
        redirect_valid = 1'b0;
        tick;
        tick;
        check("fault_sticky", 64'(fault), 64'd1);
        check("refill_valid", 64'(dec_valid), 64'd1);
        check("refill_head", dec_pc, 64'h0);
        check("refill_pc", imem_addr, 64'h8);

        // Reset with a full queue.
        rst = 1'b1;
        tick;
        check("rst_full_valid", 64'(dec_valid), 64'd0);
        check("rst_full_pc", imem_addr, 64'h0);
        check("rst_full_fault", 64'(fault), 64'd0);
        check("rst_full_halted", 64'(halted), 64'd0);

        // Redirect during BOOT is ignored; a misaligned target faults on the next fetch.
        rst             = 1'b0;
        dec_ready       = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 64'h6;
        tick;
        check("boot_ignores_redirect", imem_addr, 64'h0);
        tick;
        redirect_valid = 1'b0;
        check("misalign_target", imem_addr, 64'h6);
        tick;
        check("misalign_fault", 64'(fault), 64'd1);
        check("misalign_no_push", 64'(dec_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
